// File: rtl/seg_scan_capture.sv
// Captures a six-digit multiplexed 7-segment display scan into BCD codes and decimal points.
// Each digit must hold steady for STABLE_CNT samples before it is latched; a frame is published once all six are seen.
//
//   state    | meaning
//   IDLE     | no single digit enabled, waiting for a one-hot-low enable
//   SETTLE   | one digit enabled, waiting for STABLE_CNT identical samples
//   CAPTURED | digit latched, waiting for the enable to move on
module seg_scan_capture #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_valid,
    output logic [7:0]  o_err_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

    state_t      state_q, state_nxt;
    logic [13:0] smp_q, smp_p;
    logic        q_vld, p_vld;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [5:0]  enb_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        enb_chg, one_hot, multi_low;
    logic [2:0]  n_zero, idx;
    logic [3:0]  code;
    logic        capture, mz_err, mz_done_q, err_inc;
    logic [23:0] shadow_q;
    logic [5:0]  shadow_dp_q, seen_q, seen_nxt;
    logic        frame;

    assign enb_q = smp_q[13:8];
    assign seg_q = smp_q[7:1];
    assign dp_q  = smp_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= {6'h3f, 7'h00, 1'b0};
            smp_p <= {6'h3f, 7'h00, 1'b0};
            q_vld <= 1'b0;
            p_vld <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            smp_q <= {i_seg_enb, i_seg, i_seg_dp};
            smp_p <= smp_q;
            q_vld <= 1'b1;
            p_vld <= q_vld;
            cnt_q <= q_vld ? cnt_nxt : 8'd0;
        end
    end

    // cnt_nxt is the run length of the sample currently in smp_q; with no valid predecessor it is a change
    always_comb begin
        cnt_nxt = 8'd1;
        if (p_vld && (smp_q == smp_p))
            cnt_nxt = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
    end

    assign enb_chg   = !p_vld || (enb_q != smp_p[13:8]);
    assign n_zero    = 3'($countones(~enb_q));
    assign one_hot   = (n_zero == 3'd1);
    assign multi_low = (n_zero >= 3'd2);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++)
            if (!enb_q[i]) idx = 3'(i);
    end

    always_comb begin
        case (seg_q)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b1011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1110011: code = 4'h9;
            7'b0000000: code = 4'hE;
            default:    code = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        case (state_q)
            IDLE:     if (one_hot) state_nxt = SETTLE;
            SETTLE: begin
                if (!one_hot) begin
                    state_nxt = IDLE;
                end else if (cnt_nxt >= CNT_MAX) begin
                    state_nxt = CAPTURED;
                    capture   = 1'b1;
                end
            end
            CAPTURED: if (enb_chg) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // a multi-digit enable is reported once per hold, not once per segment glitch during it
    assign mz_err  = multi_low && (cnt_nxt >= CNT_MAX) && !mz_done_q;
    assign err_inc = mz_err || (capture && (code == 4'hF));
    assign frame   = (seen_q == 6'h3f);

    always_comb begin
        seen_nxt = frame ? 6'h00 : seen_q;
        if (capture) seen_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mz_done_q     <= 1'b0;
            o_err_cnt     <= 8'd0;
            seen_q        <= 6'h00;
            shadow_q      <= 24'hEEEEEE;
            shadow_dp_q   <= 6'h00;
            o_digits      <= 24'hEEEEEE;
            o_dp          <= 6'h00;
            o_frame_valid <= 1'b0;
        end else begin
            if (enb_chg)     mz_done_q <= 1'b0;
            else if (mz_err) mz_done_q <= 1'b1;
            if (err_inc && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
            seen_q        <= seen_nxt;
            o_frame_valid <= frame;
            if (frame) begin
                o_digits <= shadow_q;
                o_dp     <= shadow_dp_q;
            end
            if (capture) begin
                shadow_q[4*idx +: 4] <= code;
                shadow_dp_q[idx]     <= dp_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: scans scripted display frames, expected frames go to a scoreboard
// that is popped on each o_frame_valid; error counter and hold behaviour are checked directly.
module tb_seg_scan_capture;

    localparam int STABLE_CNT = 4;
    localparam int LAT_MAX    = STABLE_CNT + 3;
    localparam int HOLD       = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_valid;
    logic [7:0]  o_err_cnt;

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  dp;
    } frame_t;

    frame_t sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_frames = 0;

    seg_scan_capture #(.STABLE_CNT(STABLE_CNT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_seg         (i_seg),
        .i_seg_dp      (i_seg_dp),
        .i_seg_enb     (i_seg_enb),
        .o_digits      (o_digits),
        .o_dp          (o_dp),
        .o_frame_valid (o_frame_valid),
        .o_err_cnt     (o_err_cnt)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_frame_valid) begin
            frame_t e;
            n_frames++;
            if (sb_q.size() == 0) begin
                check_val("sb_pending", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("frame_digits", 32'(o_digits), 32'(e.digits));
                check_val("frame_dp", 32'(o_dp), 32'(e.dp));
            end
        end
    end

    task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
        i_seg_enb = enb;
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [5:0][6:0] segs, input logic [5:0] dps,
                              input logic [23:0] exp_dig, input logic [5:0] exp_dp);
        logic [5:0] enb;
        int         lat;
        logic       found;
        frame_t     e;
        e.digits = exp_dig;
        e.dp     = exp_dp;
        sb_q.push_back(e);
        for (int i = 0; i < 5; i++) begin
            enb = ~(6'b000001 << i);
            drive(enb, segs[i], dps[i], HOLD);
        end
        drive(6'b011111, segs[5], dps[5], 0);
        lat   = HOLD + 1;
        found = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            @(negedge clk);
            if (!found && o_frame_valid) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check_val("frame_latency_ok", 32'(found && (lat <= LAT_MAX)), 32'd1);
        drive(6'h3f, 7'h00, 1'b0, 10);
    endtask

    initial begin
        logic [5:0][6:0] segs;
        logic [5:0]      enb;

        rst_n     = 1'b0;
        i_seg_enb = 6'h3f;
        i_seg     = 7'h00;
        i_seg_dp  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_digits", 32'(o_digits), 32'hEEEEEE);
        check_val("rst_dp", 32'(o_dp), 32'h0);
        check_val("rst_fv", 32'(o_frame_valid), 32'h0);
        check_val("rst_err", 32'(o_err_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        segs = {seg_of(6), seg_of(5), seg_of(4), seg_of(3), seg_of(2), seg_of(1)};
        scan_frame(segs, 6'b000100, 24'h654321, 6'b000100);
        check_val("t1_frames", 32'(n_frames), 32'd1);
        check_val("t1_err", 32'(o_err_cnt), 32'd0);

        drive(6'b111110, seg_of(8), 1'b0, STABLE_CNT - 1);
        drive(6'h3f, 7'h00, 1'b0, 20);
        check_val("short_hold_frames", 32'(n_frames), 32'd1);
        check_val("short_hold_err", 32'(o_err_cnt), 32'd0);
        check_val("hold_digits", 32'(o_digits), 32'h654321);

        segs = {seg_of(5), seg_of(4), 7'b1010101, seg_of(2), seg_of(1), seg_of(0)};
        scan_frame(segs, 6'b000000, 24'h54F210, 6'b000000);
        check_val("bad_seg_err", 32'(o_err_cnt), 32'd1);
        check_val("bad_seg_code", 32'(o_digits[15:12]), 32'hF);

        drive(6'b111100, seg_of(8), 1'b0, 20);
        check_val("multi_en_err", 32'(o_err_cnt), 32'd2);
        drive(6'h3f, seg_of(8), 1'b0, 20);
        check_val("no_en_err", 32'(o_err_cnt), 32'd2);
        check_val("multi_en_frames", 32'(n_frames), 32'd2);
        check_val("multi_en_digits", 32'(o_digits), 32'h54F210);

        for (int i = 0; i < 4; i++) begin
            enb = ~(6'b000001 << i);
            drive(enb, seg_of(9 - i), 1'b0, HOLD);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_digits", 32'(o_digits), 32'hEEEEEE);
        check_val("midrst_err", 32'(o_err_cnt), 32'd0);
        i_seg_enb = 6'h3f;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        segs = {seg_of(4), seg_of(5), seg_of(6), seg_of(7), seg_of(8), seg_of(9)};
        scan_frame(segs, 6'b000000, 24'h456789, 6'b000000);
        check_val("midrst_frames", 32'(n_frames), 32'd3);

        segs = {seg_of(7), seg_of(10), seg_of(8), seg_of(9), seg_of(0), seg_of(3)};
        scan_frame(segs, 6'b100001, 24'h7E8903, 6'b100001);
        check_val("blank_err", 32'(o_err_cnt), 32'd0);

        for (int k = 1; k <= 300; k++) begin
            drive(6'b111100, seg_of(8), 1'b0, STABLE_CNT + 1);
            drive(6'h3f, seg_of(8), 1'b0, 2);
            if (k == 254) check_val("err_254", 32'(o_err_cnt), 32'd254);
            if (k == 255) check_val("err_255", 32'(o_err_cnt), 32'd255);
        end
        check_val("err_sat", 32'(o_err_cnt), 32'd255);
        check_val("final_frames", 32'(n_frames), 32'd4);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
